// File: rtl/dcache_miss_if.sv
// Miss/refill bundle between data_cache, the miss controller and main memory.
// master = cache + memory side, slave = dcache_miss_ctrl.
interface dcache_miss_if #(
  parameter int WORD_SIZE  = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [2:0]            miss_rd;
  logic [ADDR_WIDTH-1:0] addr_rd1;
  logic [ADDR_WIDTH-1:0] addr_rd2;
  logic [ADDR_WIDTH-1:0] addr_rd3;
  logic                  miss_wr;
  logic [ADDR_WIDTH-1:0] addr_wr;
  logic [3:0]            done;
  logic                  busy;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic                  mem_valid;
  logic [WORD_SIZE-1:0]  mem_data;
  logic                  fill_we;
  logic [ADDR_WIDTH-1:0] fill_addr;
  logic [WORD_SIZE-1:0]  fill_data;

  modport master (
    output miss_rd, addr_rd1, addr_rd2, addr_rd3, miss_wr, addr_wr,
    output mem_ack, mem_valid, mem_data,
    input  done, busy, mem_req, mem_addr, fill_we, fill_addr, fill_data
  );

  modport slave (
    input  miss_rd, addr_rd1, addr_rd2, addr_rd3, miss_wr, addr_wr,
    input  mem_ack, mem_valid, mem_data,
    output done, busy, mem_req, mem_addr, fill_we, fill_addr, fill_data
  );
endinterface

// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss controller: round-robin over rd1/rd2/rd3/wr, one line refill at a time.
// Define DCACHE_MISS_WRITE_ALLOCATE_EN to refill on write misses; default is write-around.
module dcache_miss_ctrl #(
  parameter int WORD_SIZE  = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WORDS = 4
) (
  input logic          clk,
  input logic          rst_n,
  dcache_miss_if.slave bus
);
  localparam int BW = $clog2(LINE_WORDS);
  localparam logic [BW-1:0]         LAST_BEAT = BW'(LINE_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL, S_DONE} state_t;

  state_t                state_q;
  logic [1:0]            prio_q;
  logic [1:0]            win_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [BW-1:0]         beat_q;
  logic [3:0]            done_q;
  logic                  busy_q;
  logic                  mem_req_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  fill_we_q;
  logic [ADDR_WIDTH-1:0] fill_addr_q;
  logic [WORD_SIZE-1:0]  fill_data_q;

  logic [3:0]            req;
  logic [1:0]            gnt_d;
  logic                  gnt_vld_d;
  logic [ADDR_WIDTH-1:0] gnt_addr_d;

  assign req = {bus.miss_wr, bus.miss_rd};

  // Scan from lowest priority up so the first requester after prio_q wins last.
  always_comb begin
    gnt_d     = prio_q;
    gnt_vld_d = |req;
    for (int k = 3; k >= 0; k--) begin
      if (req[prio_q + 2'(k)]) gnt_d = prio_q + 2'(k);
    end
    case (gnt_d)
      2'd0:    gnt_addr_d = bus.addr_rd1;
      2'd1:    gnt_addr_d = bus.addr_rd2;
      2'd2:    gnt_addr_d = bus.addr_rd3;
      default: gnt_addr_d = bus.addr_wr;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      prio_q      <= 2'd0;
      win_q       <= 2'd0;
      base_q      <= '0;
      beat_q      <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      fill_we_q   <= 1'b0;
      fill_addr_q <= '0;
      fill_data_q <= '0;
    end else begin
      fill_we_q <= 1'b0;
      done_q    <= '0;
      case (state_q)
        S_IDLE: begin
          if (gnt_vld_d) begin
            prio_q <= gnt_d + 2'd1;
            win_q  <= gnt_d;
            base_q <= gnt_addr_d & LINE_MASK;
            beat_q <= '0;
            busy_q <= 1'b1;
`ifdef DCACHE_MISS_WRITE_ALLOCATE_EN
            state_q    <= S_REQ;
            mem_req_q  <= 1'b1;
            mem_addr_q <= gnt_addr_d & LINE_MASK;
`else
            if (gnt_d == 2'd3) begin
              state_q <= S_DONE;
              done_q  <= 4'b1000;
            end else begin
              state_q    <= S_REQ;
              mem_req_q  <= 1'b1;
              mem_addr_q <= gnt_addr_d & LINE_MASK;
            end
`endif
          end
        end
        S_REQ: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= S_FILL;
          end
        end
        S_FILL: begin
          if (bus.mem_valid) begin
            fill_we_q   <= 1'b1;
            fill_addr_q <= base_q + ADDR_WIDTH'(beat_q);
            fill_data_q <= bus.mem_data;
            beat_q      <= beat_q + 1'b1;
            if (beat_q == LAST_BEAT) begin
              state_q <= S_DONE;
              done_q  <= 4'b0001 << win_q;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.fill_we   = fill_we_q;
  assign bus.fill_addr = fill_addr_q;
  assign bus.fill_data = fill_data_q;
endmodule
